// File: rtl/up_down_pkg.sv
// up_down_pkg
//   Shared definitions for the UP/DOWN guessing-game judge: game state
//   encoding, LFSR width/type and the LFSR step function.
package up_down_pkg;

  localparam int unsigned LFSR_W = 4;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  // Shift left, feed back bit3 ^ bit2 into bit0 (1011 -> 0111 -> 1111 -> 1110 ...).
  function automatic lfsr_t lfsr_next(input lfsr_t cur);
    return {cur[LFSR_W-2:0], cur[3] ^ cur[2]};
  endfunction

endpackage

// File: rtl/up_down_btn_edge.sv
// up_down_btn_edge
//   Registered rising-edge one-shot for a raw level button. PULSE is high for
//   exactly one cycle, the cycle after the edge that first sees LEVEL=1 with
//   the previous sample at 0. A held button yields a single pulse.
// Ports:
//   CLK    in  clock, posedge
//   RESETN in  synchronous active-low reset (clears history and pulse)
//   LEVEL  in  raw button level
//   PULSE  out one-cycle registered pulse
module up_down_btn_edge
  import up_down_pkg::*;
(
  input  logic CLK,
  input  logic RESETN,
  input  logic LEVEL,
  output logic PULSE
);

  logic prev;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      prev  <= '0;
      PULSE <= '0;
    end else begin
      prev  <= LEVEL;
      PULSE <= LEVEL & ~prev;
    end
  end

endmodule

// File: rtl/up_down_judge.sv
// up_down_judge
//   Judge side of the UP/DOWN number-guessing game. A free-running LFSR
//   supplies the secret on each new game; each accepted SUBMIT compares GUESS
//   with the secret and reports UP / DOWN / CORRECT, counting tries up to
//   MAX_TRIES.
// Parameters:
//   MAX_VALUE  highest legal guess/secret, 2^k-1 (1,3,7,15)
//   MAX_TRIES  submits allowed per game (1..15)
//   SEED       nonzero LFSR reset value
// Ports:
//   CLK, RESETN          clock / synchronous active-low reset
//   GUESS[3:0]           guess sampled on an accepted submit
//   SUBMIT, NEW_GAME     raw level buttons
//   HINT_UP, HINT_DOWN   last valid guess below / above the secret
//   CORRECT, GAME_OVER   game won / game lost
//   INVALID              last submit was above MAX_VALUE
//   PLAYING              game in progress
//   TRIES[3:0]           accepted submits this game
//   SECRET[3:0]          current secret
module up_down_judge
  import up_down_pkg::*;
#(
  parameter int unsigned MAX_VALUE = 3,
  parameter int unsigned MAX_TRIES = 4,
  parameter logic [3:0]  SEED      = 4'b1011
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [3:0] GUESS,
  input  logic       SUBMIT,
  input  logic       NEW_GAME,
  output logic       HINT_UP,
  output logic       HINT_DOWN,
  output logic       CORRECT,
  output logic       GAME_OVER,
  output logic       INVALID,
  output logic       PLAYING,
  output logic [3:0] TRIES,
  output logic [3:0] SECRET
);

  localparam lfsr_t MAX_V     = lfsr_t'(MAX_VALUE);
  localparam lfsr_t TRY_LIMIT = lfsr_t'(MAX_TRIES);

  state_t state;
  lfsr_t  lfsr;
  logic   sub_pulse;
  logic   ng_pulse;
  lfsr_t  tries_inc;

  up_down_btn_edge u_sub_edge (
    .CLK    (CLK),
    .RESETN (RESETN),
    .LEVEL  (SUBMIT),
    .PULSE  (sub_pulse)
  );

  up_down_btn_edge u_ng_edge (
    .CLK    (CLK),
    .RESETN (RESETN),
    .LEVEL  (NEW_GAME),
    .PULSE  (ng_pulse)
  );

  assign tries_inc = TRIES + 4'd1;
  assign PLAYING   = (state == PLAY);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state     <= IDLE;
      lfsr      <= SEED;
      SECRET    <= '0;
      TRIES     <= '0;
      HINT_UP   <= '0;
      HINT_DOWN <= '0;
      CORRECT   <= '0;
      GAME_OVER <= '0;
      INVALID   <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);

      // NEW_GAME has priority in every state; a simultaneous submit is dropped.
      if (ng_pulse) begin
        SECRET    <= lfsr & MAX_V;
        TRIES     <= '0;
        HINT_UP   <= '0;
        HINT_DOWN <= '0;
        CORRECT   <= '0;
        GAME_OVER <= '0;
        INVALID   <= '0;
        state     <= PLAY;
      end else if (sub_pulse && state == PLAY) begin
        if (GUESS > MAX_V) begin
          INVALID <= '1;
        end else begin
          INVALID <= '0;
          TRIES   <= tries_inc;
          if (GUESS == SECRET) begin
            CORRECT   <= '1;
            HINT_UP   <= '0;
            HINT_DOWN <= '0;
            state     <= WIN;
          end else begin
            HINT_UP   <= (GUESS < SECRET);
            HINT_DOWN <= (GUESS > SECRET);
            if (tries_inc == TRY_LIMIT) begin
              GAME_OVER <= '1;
              state     <= LOSE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_up_down_judge.sv
module tb_up_down_judge;

  localparam int unsigned MAXV   = 3;
  localparam int unsigned MTRIES = 4;
  localparam logic [3:0]  SEEDV  = 4'b1011;

  logic       CLK;
  logic       RESETN;
  logic [3:0] GUESS;
  logic       SUBMIT;
  logic       NEW_GAME;
  logic       HINT_UP, HINT_DOWN, CORRECT, GAME_OVER, INVALID, PLAYING;
  logic [3:0] TRIES;
  logic [3:0] SECRET;

  int unsigned total = 0;
  int unsigned bad   = 0;

  up_down_judge #(
    .MAX_VALUE (MAXV),
    .MAX_TRIES (MTRIES),
    .SEED      (SEEDV)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .GUESS     (GUESS),
    .SUBMIT    (SUBMIT),
    .NEW_GAME  (NEW_GAME),
    .HINT_UP   (HINT_UP),
    .HINT_DOWN (HINT_DOWN),
    .CORRECT   (CORRECT),
    .GAME_OVER (GAME_OVER),
    .INVALID   (INVALID),
    .PLAYING   (PLAYING),
    .TRIES     (TRIES),
    .SECRET    (SECRET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed outputs packed: up,down,correct,over,invalid,playing,tries,secret
  logic [13:0] dut_vec;
  assign dut_vec = {HINT_UP, HINT_DOWN, CORRECT, GAME_OVER, INVALID, PLAYING, TRIES, SECRET};

  // ---------------- reference model ----------------
  int unsigned cur_lfsr;   // value the design's LFSR holds during the current cycle
  int unsigned m_secret, m_tries;
  bit m_up, m_down, m_corr, m_over, m_inv, m_playing;

  function automatic int unsigned step_lfsr(input int unsigned v);
    return ((v * 2) % 16) + (((v / 8) ^ (v / 4)) % 2);
  endfunction

  always @(posedge CLK) begin
    if (!RESETN) cur_lfsr <= SEEDV;
    else         cur_lfsr <= step_lfsr(cur_lfsr);
  end

  function automatic logic [13:0] model_vec();
    logic [3:0] t, s;
    t = 4'(m_tries);
    s = 4'(m_secret);
    return {m_up, m_down, m_corr, m_over, m_inv, m_playing, t, s};
  endfunction

  task automatic model_reset();
    m_secret = 0; m_tries = 0;
    m_up = 0; m_down = 0; m_corr = 0; m_over = 0; m_inv = 0; m_playing = 0;
  endtask

  task automatic model_new_game(input int unsigned lf);
    m_secret = lf % (MAXV + 1);
    m_tries = 0;
    m_up = 0; m_down = 0; m_corr = 0; m_over = 0; m_inv = 0;
    m_playing = 1;
  endtask

  task automatic model_submit(input int unsigned g);
    if (!m_playing) return;
    if (g > MAXV) begin
      m_inv = 1;
    end else begin
      m_inv = 0;
      m_tries = m_tries + 1;
      if (g == m_secret) begin
        m_corr = 1; m_up = 0; m_down = 0; m_playing = 0;
      end else begin
        m_up   = (g < m_secret);
        m_down = (g > m_secret);
        if (m_tries == MTRIES) begin
          m_over = 1; m_playing = 0;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Press for 'hold' sampled edges (>=2); the design acts on the second one.
  task automatic press(input logic sub, input logic ng, input logic [3:0] g,
                       input int unsigned hold);
    @(negedge CLK);
    GUESS = g; SUBMIT = sub; NEW_GAME = ng;
    @(posedge CLK);
    @(posedge CLK);
    if (ng)       model_new_game(cur_lfsr);
    else if (sub) model_submit(g);
    if (hold > 2) repeat (hold - 2) @(posedge CLK);
    @(negedge CLK);
    SUBMIT = 1'b0; NEW_GAME = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic enter_reset();
    @(negedge CLK);
    RESETN = 1'b0; SUBMIT = 1'b0; NEW_GAME = 1'b0;
    repeat (2) @(posedge CLK);
    model_reset();
    @(negedge CLK);
  endtask

  function automatic logic [3:0] wrong_guess();
    logic [3:0] g;
    g = 4'($urandom_range(0, MAXV));
    if (32'(g) == m_secret) g = 4'((m_secret + 1) % (MAXV + 1));
    return g;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    enter_reset();
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL reset: got %h want %h", dut_vec, model_vec());
    end
    total++;
    RESETN = 1'b1;
  endtask

  task automatic test_new_game();
    repeat ($urandom_range(0, 5)) @(negedge CLK);
    press(1'b0, 1'b1, 4'd0, 2);
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL new_game: got %h want %h", dut_vec, model_vec());
    end
    total++;
  endtask

  task automatic test_hints();
    bit found = 0;
    logic [3:0] gs [4];
    gs[0] = 4'd1; gs[1] = 4'd3; gs[2] = 4'd2; gs[3] = 4'd0;
    for (int i = 0; i < 40 && !found; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      press(1'b0, 1'b1, 4'd0, 2);
      if (m_secret == 2) found = 1;
    end
    if (!found) begin
      bad++; total++;
      $display("FAIL hint_setup: got no secret=2 game want secret 2");
      return;
    end
    if (SECRET !== 4'd2) begin
      bad++; $display("FAIL hint_secret: got %0d want 2", SECRET);
    end
    total++;
    for (int unsigned i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, gs[i], 2);
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL hint_step%0d: got %h want %h", i, dut_vec, model_vec());
      end
      total++;
    end
  endtask

  task automatic test_lose();
    // four wrong guesses -> loss, then submits are ignored
    press(1'b0, 1'b1, 4'd0, 2);
    for (int unsigned i = 0; i < MTRIES + 1; i++) begin
      press(1'b1, 1'b0, wrong_guess(), 2);
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL lose_try%0d: got %h want %h", i, dut_vec, model_vec());
      end
      total++;
    end
    // wrong guesses then correct on the final try -> win
    press(1'b0, 1'b1, 4'd0, 2);
    for (int unsigned i = 0; i < MTRIES - 1; i++) press(1'b1, 1'b0, wrong_guess(), 2);
    press(1'b1, 1'b0, 4'(m_secret), 2);
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL last_try_win: got %h want %h", dut_vec, model_vec());
    end
    total++;
  endtask

  task automatic test_invalid_hold();
    press(1'b0, 1'b1, 4'd0, 2);
    press(1'b1, 1'b0, 4'd9, 2);
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL invalid: got %h want %h", dut_vec, model_vec());
    end
    total++;
    press(1'b1, 1'b0, wrong_guess(), 20);
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL held_submit: got %h want %h", dut_vec, model_vec());
    end
    total++;
    press(1'b1, 1'b0, 4'd15, 3);
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL invalid_15: got %h want %h", dut_vec, model_vec());
    end
    total++;
  endtask

  task automatic test_back_to_back();
    press(1'b0, 1'b1, 4'd0, 2);
    press(1'b1, 1'b0, wrong_guess(), 2);
    press(1'b1, 1'b1, wrong_guess(), 2);
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL both_pressed: got %h want %h", dut_vec, model_vec());
    end
    total++;
    press(1'b1, 1'b0, wrong_guess(), 2);
    enter_reset();
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL midgame_reset: got %h want %h", dut_vec, model_vec());
    end
    total++;
    RESETN = 1'b1;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 80; i++) begin
      int unsigned r;
      logic [3:0] g;
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      r = $urandom_range(0, 99);
      g = (r % 10 < 7) ? 4'($urandom_range(0, MAXV)) : 4'($urandom_range(0, 15));
      if (r < 20)      press(1'b0, 1'b1, g, $urandom_range(2, 5));
      else if (r < 25) press(1'b1, 1'b1, g, 2);
      else             press(1'b1, 1'b0, g, $urandom_range(2, 5));
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL random%0d: got %h want %h", i, dut_vec, model_vec());
      end
      total++;
    end
  endtask

  initial begin
    RESETN = 1'b0; SUBMIT = 1'b0; NEW_GAME = 1'b0; GUESS = 4'd0;
    model_reset();
    test_reset();
    test_new_game();
    test_hints();
    test_lose();
    test_invalid_hold();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
